// File: rtl/router_in_arbiter.sv
// Packet-granular round-robin arbiter that lets NUM_SRC sources share the router 1x3 input port.
// Forwards one whole packet (header, payload, parity) per grant so the router never sees interleaving.
module router_in_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int DW       = 8,
    parameter int START_TO = 16,
    parameter int TAIL_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_req_i,
    input  logic [NUM_SRC-1:0]    src_pkt_valid_i,
    input  logic [NUM_SRC*DW-1:0] src_data_i,
    input  logic                  busy_i,
    output logic [NUM_SRC-1:0]    src_gnt_o,
    output logic [NUM_SRC-1:0]    src_busy_o,
    output logic [2:0]            gnt_id_o,
    output logic                  arb_active_o,
    output logic                  pkt_valid_o,
    output logic [DW-1:0]         data_in_o,
    output logic                  timeout_err_o
);

    localparam int CNT_MAX = (START_TO > TAIL_CYC) ? START_TO : TAIL_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        XFER,
        TAIL,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [2:0]         gnt_id_q, gnt_id_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [2:0]         pick_id;
    logic               sel_valid;
    logic [DW-1:0]      sel_data;

    // Round-robin search: first requester at or above rr_ptr, otherwise wrap to the lowest one.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int c = 0; c < NUM_SRC; c++) begin
            if (!pick_found && src_req_i[c] && (3'(c) >= rr_ptr_q)) begin
                pick_found = 1'b1;
                pick_id    = 3'(c);
            end
        end
        for (int c = 0; c < NUM_SRC; c++) begin
            if (!pick_found && src_req_i[c]) begin
                pick_found = 1'b1;
                pick_id    = 3'(c);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_id_q == 3'(i)) begin
                sel_valid = src_pkt_valid_i[i];
                sel_data  = src_data_i[i*DW +: DW];
            end
        end
    end

    assign arb_active_o  = (state_q == GRANT) || (state_q == XFER) || (state_q == TAIL);
    assign pkt_valid_o   = ((state_q == GRANT) || (state_q == XFER)) && sel_valid;
    assign data_in_o     = arb_active_o ? sel_data : '0;
    assign src_busy_o    = arb_active_o ? (~gnt_q | (gnt_q & {NUM_SRC{busy_i}})) : '1;
    assign src_gnt_o     = gnt_q;
    assign gnt_id_o      = gnt_id_q;
    assign timeout_err_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    gnt_d    = NUM_SRC'(1) << pick_id;
                    gnt_id_d = pick_id;
                    rr_ptr_d = (pick_id == 3'(NUM_SRC-1)) ? 3'd0 : pick_id + 3'd1;
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                if (sel_valid) begin
                    state_d = XFER;
                end else if (cnt_q == CW'(START_TO-1)) begin
                    timeout_d = 1'b1;
                    gnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (!sel_valid) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end
            end
            // Parity drain: only non-busy cycles count, so the router really accepts the tail.
            TAIL: begin
                if (!busy_i) begin
                    if (cnt_q == CW'(TAIL_CYC-1)) begin
                        gnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_router_in_arbiter.sv
// Testbench for router_in_arbiter: bench-driven sources with a round-robin/packet-stream reference model.
module tb_router_in_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int DW       = 8;
    localparam int START_TO = 16;
    localparam int TAIL_CYC = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_SRC-1:0]    src_req;
    logic [NUM_SRC-1:0]    src_pkt_valid;
    logic [NUM_SRC*DW-1:0] src_data;
    logic                  busy;
    logic [NUM_SRC-1:0]    src_gnt_o;
    logic [NUM_SRC-1:0]    src_busy_o;
    logic [2:0]            gnt_id_o;
    logic                  arb_active_o;
    logic                  pkt_valid_o;
    logic [DW-1:0]         data_in_o;
    logic                  timeout_err_o;

    int checks = 0;
    int passes = 0;
    int mdl_ptr = 0;

    router_in_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DW      (DW),
        .START_TO(START_TO),
        .TAIL_CYC(TAIL_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_req_i      (src_req),
        .src_pkt_valid_i(src_pkt_valid),
        .src_data_i     (src_data),
        .busy_i         (busy),
        .src_gnt_o      (src_gnt_o),
        .src_busy_o     (src_busy_o),
        .gnt_id_o       (gnt_id_o),
        .arb_active_o   (arb_active_o),
        .pkt_valid_o    (pkt_valid_o),
        .data_in_o      (data_in_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < NUM_SRC; k++)
            if (req[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        src_req = '0;
        src_pkt_valid = '0;
        src_data = '0;
        busy = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        mdl_ptr = 0;
    endtask

    task automatic wait_grant(input int exp_src, input string name);
        int n = 0;
        do begin
            cyc();
            settle();
            n++;
        end while (src_gnt_o == '0 && n < 64);
        checks++;
        if (src_gnt_o !== 4'(1 << exp_src) || gnt_id_o !== 3'(exp_src) || arb_active_o !== 1'b1)
            $display("[TB] FAIL %s: gnt=%b id=%0d active=%b, required gnt=%b id=%0d active=1",
                     name, src_gnt_o, gnt_id_o, arb_active_o, 4'(1 << exp_src), exp_src);
        else passes++;
    endtask

    // Source-side behaviour for the granted source: header+payload with pkt_valid=1, then parity.
    task automatic send_pkt(input int src, input int plen, input int stall_at,
                            input int stall_len, input bit drop_req);
        logic [7:0] exp_q[$];
        logic [7:0] obs_q[$];
        logic [7:0] par;
        logic [3:0] exp_busy;
        int i, stalled, guard, held, wrong;
        exp_q.push_back({6'(plen), 2'($urandom_range(0, 2))});
        for (int k = 0; k < plen; k++) exp_q.push_back(8'($urandom));
        par = 8'h00;
        foreach (exp_q[j]) par ^= exp_q[j];
        i = 0; stalled = 0; guard = 0;
        while (i < exp_q.size() && guard < 100) begin
            cyc();
            guard++;
            src_pkt_valid[src] = 1'b1;
            src_data[src*8 +: 8] = exp_q[i];
            busy = (i == stall_at) && (stalled < stall_len);
            if (busy) stalled++;
            settle();
            exp_busy = 4'hF;
            exp_busy[src] = busy;
            checks++;
            if (src_busy_o !== exp_busy)
                $display("[TB] FAIL src_busy: got %b, required %b", src_busy_o, exp_busy);
            else passes++;
            if (busy) begin
                checks++;
                if (arb_active_o !== 1'b1 || pkt_valid_o !== 1'b1 || data_in_o !== exp_q[i])
                    $display("[TB] FAIL stall_hold: active=%b pv=%b data=%h, required 1 1 %h",
                             arb_active_o, pkt_valid_o, data_in_o, exp_q[i]);
                else passes++;
            end else begin
                if (pkt_valid_o === 1'b1) obs_q.push_back(data_in_o);
                i++;
            end
        end
        cyc();
        busy = 1'b0;
        src_pkt_valid[src] = 1'b0;
        src_data[src*8 +: 8] = par;
        if (drop_req) src_req[src] = 1'b0;
        settle();
        if (pkt_valid_o === 1'b0 && arb_active_o === 1'b1) obs_q.push_back(data_in_o);
        exp_q.push_back(par);
        wrong = 0;
        if (obs_q.size() != exp_q.size()) wrong = 1;
        else foreach (exp_q[j]) if (obs_q[j] !== exp_q[j]) wrong++;
        checks++;
        if (wrong != 0)
            $display("[TB] FAIL stream src%0d: %0d bytes seen (%0d wrong), required %0d exact bytes",
                     src, obs_q.size(), wrong, exp_q.size());
        else passes++;
        held = 0;
        for (int t = 0; t < 10; t++) begin
            cyc();
            settle();
            if (src_gnt_o[src] !== 1'b1) break;
            held++;
        end
        checks++;
        if (held != TAIL_CYC)
            $display("[TB] FAIL tail_len: grant held %0d cycles after parity, required %0d", held, TAIL_CYC);
        else passes++;
        checks++;
        if (src_gnt_o !== 4'h0 || pkt_valid_o !== 1'b0 || arb_active_o !== 1'b0 || data_in_o !== 8'h00)
            $display("[TB] FAIL gap: gnt=%b pv=%b active=%b data=%h, required 0000 0 0 00",
                     src_gnt_o, pkt_valid_o, arb_active_o, data_in_o);
        else passes++;
        cyc();
        src_data[src*8 +: 8] = 8'h00;
        settle();
        checks++;
        if (src_gnt_o !== 4'h0)
            $display("[TB] FAIL idle_after_gap: gnt=%b, required 0000", src_gnt_o);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_req = 4'hF;
        src_pkt_valid = 4'hF;
        src_data = 32'hDEADBEEF;
        busy = 1'b0;
        for (int r = 0; r < 3; r++) begin
            cyc();
            settle();
            checks++;
            if (src_gnt_o !== 4'h0 || pkt_valid_o !== 1'b0 || src_busy_o !== 4'hF ||
                arb_active_o !== 1'b0 || data_in_o !== 8'h00 || gnt_id_o !== 3'd0 || timeout_err_o !== 1'b0)
                $display("[TB] FAIL reset: gnt=%b pv=%b busy=%b act=%b data=%h id=%0d to=%b, required 0000 0 1111 0 00 0 0",
                         src_gnt_o, pkt_valid_o, src_busy_o, arb_active_o, data_in_o, gnt_id_o, timeout_err_o);
            else passes++;
        end
        src_req = '0;
        src_pkt_valid = '0;
        src_data = '0;
        rst = 1'b0;
        mdl_ptr = 0;
    endtask

    task automatic test_single_source();
        apply_reset();
        src_req = 4'b0100;
        settle();
        checks++;
        if (src_gnt_o !== 4'h0)
            $display("[TB] FAIL gnt_registered: gnt=%b, required 0000", src_gnt_o);
        else passes++;
        cyc();
        settle();
        checks++;
        if (src_gnt_o !== 4'b0100 || gnt_id_o !== 3'd2)
            $display("[TB] FAIL gnt_one_cycle: gnt=%b id=%0d, required 0100 2", src_gnt_o, gnt_id_o);
        else passes++;
        mdl_ptr = 3;
        send_pkt(2, 3, -1, 0, 1'b1);
    endtask

    task automatic test_contention();
        int w;
        apply_reset();
        src_req = 4'hF;
        for (int p = 0; p < 5; p++) begin
            w = rr_pick(src_req, mdl_ptr);
            wait_grant(w, "contention_order");
            mdl_ptr = (w + 1) % NUM_SRC;
            send_pkt(w, $urandom_range(1, 4), -1, 0, 1'b0);
        end
        src_req = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        src_req = 4'b1000;
        wait_grant(3, "stall_grant");
        mdl_ptr = 0;
        send_pkt(3, 6, 2, 5, 1'b1);
    endtask

    task automatic test_timeout();
        int n, pulses;
        apply_reset();
        src_req = 4'b0110;
        wait_grant(rr_pick(src_req, mdl_ptr), "timeout_grant");
        mdl_ptr = 2;
        n = 1;
        pulses = 0;
        for (int t = 0; t < 40; t++) begin
            cyc();
            settle();
            if (timeout_err_o === 1'b1) pulses++;
            if (src_gnt_o[1] !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != START_TO)
            $display("[TB] FAIL timeout_len: grant held %0d cycles, required %0d", n, START_TO);
        else passes++;
        checks++;
        if (timeout_err_o !== 1'b1 || src_gnt_o !== 4'h0)
            $display("[TB] FAIL timeout_gap: to=%b gnt=%b, required 1 0000", timeout_err_o, src_gnt_o);
        else passes++;
        cyc();
        settle();
        if (timeout_err_o === 1'b1) pulses++;
        checks++;
        if (pulses != 1)
            $display("[TB] FAIL timeout_pulse: %0d pulse cycles, required 1", pulses);
        else passes++;
        src_req[1] = 1'b0;
        wait_grant(rr_pick(src_req, mdl_ptr), "after_timeout");
        mdl_ptr = 3;
        send_pkt(2, 2, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        src_req = 4'b0100;
        wait_grant(2, "pre_reset_grant");
        cyc();
        src_pkt_valid[2] = 1'b1;
        src_data[23:16] = 8'h0D;
        cyc();
        src_data[23:16] = 8'hA5;
        settle();
        checks++;
        if (pkt_valid_o !== 1'b1 || data_in_o !== 8'hA5)
            $display("[TB] FAIL pre_reset_xfer: pv=%b data=%h, required 1 a5", pkt_valid_o, data_in_o);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (src_gnt_o !== 4'h0 || pkt_valid_o !== 1'b0 || data_in_o !== 8'h00 || src_busy_o !== 4'hF ||
            arb_active_o !== 1'b0 || gnt_id_o !== 3'd0)
            $display("[TB] FAIL async_reset: gnt=%b pv=%b data=%h busy=%b act=%b id=%0d, required 0000 0 00 1111 0 0",
                     src_gnt_o, pkt_valid_o, data_in_o, src_busy_o, arb_active_o, gnt_id_o);
        else passes++;
        cyc();
        cyc();
        src_pkt_valid = '0;
        src_data = '0;
        src_req = 4'b1100;
        rst = 1'b0;
        mdl_ptr = 0;
        wait_grant(rr_pick(src_req, mdl_ptr), "rr_ptr_after_reset");
        mdl_ptr = 3;
        send_pkt(2, 1, -1, 0, 1'b1);
        src_req = '0;
    endtask

    task automatic test_random();
        int w;
        apply_reset();
        for (int p = 0; p < 12; p++) begin
            src_req = src_req | 4'($urandom_range(1, 15));
            w = rr_pick(src_req, mdl_ptr);
            wait_grant(w, "random_grant");
            mdl_ptr = (w + 1) % NUM_SRC;
            send_pkt(w, $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end
        src_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_stall();
        test_timeout();
        test_reset_mid_xfer();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
